keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad. It drives the column lines one at a time and waits a settle interval on each. When a row reads back active it debounces the press and encodes it as a 4-bit key code. Codes are buffered in a small FIFO read by downstream logic over a valid/ready handshake. It replaces the free-running scan loop in the keypad path with timed, debounced, buffered key delivery.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/key_fifo.sv | 57 +++++
 rtl/keypad_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan controller.
// Optional auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [2:0] {
        DRIVE,
        SAMPLE,
        DEBOUNCE,
        PUSH,
        HELD
    } scan_state_t;

    // Multi-row presses resolve to the lowest row index.
    function automatic logic [1:0] lowest_row_idx(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [COLS-1:0] col_onehot(input logic [1:0] idx);
        logic [COLS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO with a registered head word; push and pop in the same
// cycle are both honoured, including a push into a full FIFO that is popping.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [AW-1:0]    w_rd_ptr_next;

    assign o_full        = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok      = i_pop && (r_count != '0);
    assign w_push_ok     = i_push && (!o_full || w_pop_ok);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    // Head register looks ahead to the next read slot, bypassing a write to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
            if (w_push_ok && (r_wr_ptr == w_rd_ptr_next)) r_head <= i_data;
            else                                          r_head <= r_mem[w_rd_ptr_next];
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_count != '0);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, settle, debounce, encode, FIFO delivery.
// Define KEYPAD_AUTOREPEAT_EN to re-push a held key every REPEAT_CYC cycles.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output key_code_t       key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            overflow,
    input  logic            clr_overflow,
    output logic            pressed
);

    localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [ROWS-1:0] r_row_meta;
    logic [ROWS-1:0] r_row_s;
    scan_state_t     r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_col_idx;
    logic [COLS-1:0] r_col;
    logic [ROWS-1:0] r_snap;
    key_code_t       r_code;
    logic            r_pressed;
    logic            r_overflow;

    logic            w_push;
    logic            w_pop;
    logic            w_full;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REPEAT_CYC = 1024;
    localparam int RW         = $clog2(REPEAT_CYC);
    logic [RW-1:0]   r_rep_cnt;
    logic            r_rep_fire;
    assign w_push = (r_state == PUSH) || r_rep_fire;
`else
    assign w_push = (r_state == PUSH);
`endif

    assign w_pop = key_valid && key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= '0;
            r_row_s    <= '0;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= DRIVE;
            r_cnt     <= '0;
            r_col_idx <= 2'd0;
            r_col     <= col_onehot(2'd0);
            r_snap    <= '0;
            r_code    <= '0;
            r_pressed <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt  <= '0;
            r_rep_fire <= 1'b0;
`endif
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_fire <= 1'b0;
`endif
            case (r_state)
                DRIVE: begin
                    if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SAMPLE: begin
                    if (r_row_s == '0) begin
                        r_col_idx <= r_col_idx + 2'd1;
                        r_col     <= col_onehot(r_col_idx + 2'd1);
                        r_state   <= DRIVE;
                    end else begin
                        r_snap  <= r_row_s;
                        r_code  <= {lowest_row_idx(r_row_s), r_col_idx};
                        r_cnt   <= '0;
                        r_state <= DEBOUNCE;
                    end
                end
                // The SAMPLE cycle already matched, so DEBOUNCE_CYC-1 more are needed.
                DEBOUNCE: begin
                    if (r_row_s != r_snap) begin
                        r_cnt   <= '0;
                        r_state <= DRIVE;
                    end else if (r_cnt == CW'(DEBOUNCE_CYC - 2)) begin
                        r_cnt     <= '0;
                        r_pressed <= 1'b1;
                        r_state   <= PUSH;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PUSH: begin
                    r_cnt   <= '0;
                    r_state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    r_rep_cnt <= '0;
`endif
                end
                HELD: begin
                    if (r_row_s != '0) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                        r_cnt     <= '0;
                        r_pressed <= 1'b0;
                        r_col_idx <= r_col_idx + 2'd1;
                        r_col     <= col_onehot(r_col_idx + 2'd1);
                        r_state   <= DRIVE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (r_row_s == r_snap) begin
                        if (r_rep_cnt == RW'(REPEAT_CYC - 1)) begin
                            r_rep_cnt  <= '0;
                            r_rep_fire <= 1'b1;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + RW'(1);
                        end
                    end else begin
                        r_rep_cnt <= '0;
                    end
`endif
                end
                default: r_state <= DRIVE;
            endcase
        end
    end

    // A simultaneous pop makes room, so only an unpopped full FIFO drops the code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_code_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (r_code),
        .i_pop   (w_pop),
        .o_data  (key_code),
        .o_valid (key_valid),
        .o_full  (w_full)
    );

    assign col      = r_col;
    assign pressed  = r_pressed;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboarded bench for keypad_scan_ctrl: a keypad matrix model drives rows
// from the column lines; a negedge monitor checks every delivered key code.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;
    logic       clr_overflow;
    logic       pressed;

    logic       key_on;
    logic [3:0] key_rows;
    logic [1:0] key_col;
    logic       force_en;
    logic [3:0] force_val;

    int         errors = 0;
    int         checks = 0;
    int         popped = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    always #5 clk = ~clk;

    assign row = force_en ? force_val : ((key_on && col[key_col]) ? key_rows : 4'b0000);

    keypad_scan_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row          (row),
        .col          (col),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .pressed      (pressed)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: one line per delivered key code.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_code: got %b required none", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("key_code", {28'd0, key_code}, {28'd0, mon_exp});
                popped++;
                $display("key delivered: code=%b expected=%b", key_code, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col !== target && n < 200) begin
            tick();
            n++;
        end
        check("wait_col", {28'd0, col}, {28'd0, target});
    endtask

    task automatic wait_col_start(input logic [3:0] target);
        int n;
        n = 0;
        while (col === target && n < 200) begin
            tick();
            n++;
        end
        wait_col(target);
    endtask

    task automatic wait_pressed(input logic v, input int bound);
        int n;
        n = 0;
        while (pressed !== v && n < bound) begin
            tick();
            n++;
        end
        check("wait_pressed", {31'd0, pressed}, {31'd0, v});
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic press(input logic [3:0] rows, input logic [1:0] c, input int hold);
        logic [3:0] target;
        target = 4'b0001 << c;
        wait_col_start(target);
        key_rows = rows;
        key_col  = c;
        key_on   = 1'b1;
        wait_pressed(1'b1, 60);
        repeat (hold) tick();
        key_on = 1'b0;
        wait_pressed(1'b0, 60);
    endtask

    logic [3:0] k_rows [5];
    logic [1:0] k_cols [5];
    logic [3:0] k_code [5];

    initial begin
        rst_n = 1'b0; key_ready = 1'b0; clr_overflow = 1'b0;
        key_on = 1'b0; key_rows = '0; key_col = '0; force_en = 1'b0; force_val = '0;
        k_rows = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        k_cols = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        k_code = '{4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b0010};
        repeat (3) tick();
        check("rst_col", {28'd0, col}, 32'h1);
        check("rst_valid", {31'd0, key_valid}, 0);
        check("rst_code", {28'd0, key_code}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_pressed", {31'd0, pressed}, 0);
        rst_n = 1'b1;

        // Idle scan: each column held 5 cycles.
        for (int k = 0; k < 40; k++) begin
            check("idle_col", {28'd0, col}, 32'h1 << ((k / 5) % 4));
            check("idle_valid", {31'd0, key_valid}, 0);
            tick();
        end

        // Single press on row 2, col 1.
        key_ready = 1'b1;
        wait_col_start(4'b0010);
        exp_q.push_back(4'b1001);
        key_rows = 4'b0100; key_col = 2'd1; key_on = 1'b1;
        begin
            int n;
            n = 0;
            while (key_valid !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("latency_ok", {31'd0, (key_valid === 1'b1) && (n <= 24)}, 1);
            repeat (30 - n) tick();
        end
        check("held_pressed", {31'd0, pressed}, 1);
        check("held_col", {28'd0, col}, 32'h2);
        key_on = 1'b0;
        repeat (10) tick();
        check("release_pressed_still", {31'd0, pressed}, 1);
        wait_pressed(1'b0, 20);
        check("after_release_col", {28'd0, col}, 32'h4);
        check("single_pop", popped, 1);

        // Glitch on col 0: no push, same column re-driven.
        wait_col_start(4'b0001);
        force_val = 4'b0001; force_en = 1'b1;
        repeat (5) tick();
        force_en = 1'b0;
        repeat (5) tick();
        check("glitch_same_col", {28'd0, col}, 32'h1);
        check("glitch_no_valid", {31'd0, key_valid}, 0);
        check("glitch_not_pressed", {31'd0, pressed}, 0);
        repeat (3) tick();
        check("glitch_scan_resumes", {28'd0, col}, 32'h2);

        // Fill FIFO with consumer stalled, fifth press overflows.
        key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(k_code[i]);
            press(k_rows[i], k_cols[i], 5);
            if (i == 3) check("no_overflow_at_4", {31'd0, overflow}, 0);
        end
        check("overflow_set", {31'd0, overflow}, 1);
        check("full_valid", {31'd0, key_valid}, 1);
        check("full_head", {28'd0, key_code}, 0);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("overflow_cleared", {31'd0, overflow}, 0);
        key_ready = 1'b1;
        wait_drain(20);
        tick();
        check("drained_valid", {31'd0, key_valid}, 0);
        check("drained_count", popped, 5);

        // Multi-row press: lowest row wins.
        exp_q.push_back(4'b0100);
        press(4'b0110, 2'd0, 5);
        wait_drain(20);

        // Reset mid-debounce with two codes buffered.
        key_ready = 1'b0;
        press(4'b1000, 2'd1, 3);
        press(4'b0100, 2'd3, 3);
        check("pre_reset_valid", {31'd0, key_valid}, 1);
        check("pre_reset_head", {28'd0, key_code}, 32'hD);
        wait_col_start(4'b0100);
        key_rows = 4'b1000; key_col = 2'd2; key_on = 1'b1;
        repeat (10) tick();
        check("in_debounce_col", {28'd0, col}, 32'h4);
        check("in_debounce_pressed", {31'd0, pressed}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", {28'd0, col}, 32'h1);
        check("mid_rst_valid", {31'd0, key_valid}, 0);
        check("mid_rst_code", {28'd0, key_code}, 0);
        check("mid_rst_overflow", {31'd0, overflow}, 0);
        check("mid_rst_pressed", {31'd0, pressed}, 0);
        key_on = 1'b0;
        tick();
        rst_n = 1'b1;
        key_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("restart_col", {28'd0, col}, 32'h1 << ((k / 5) % 4));
            check("restart_valid", {31'd0, key_valid}, 0);
            tick();
        end
        check("final_pops", popped, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
